// File: rtl/max_pool_stream_scheduler.sv
// Run sequencer ahead of the max-pool collector: gates the pooling stream, tags the last group of
// each channel map and pulses done after every map's final packet has left the collector.
module max_pool_stream_scheduler #(
  parameter int  feature_n_per_clk  = 4,
  parameter int  feature_data_width = 8,
  parameter real simulation_delay   = 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic [15:0]                                         cfg_grp_per_row,
  input  logic [15:0]                                         cfg_row_n,
  input  logic [15:0]                                         cfg_chn_n,
  output logic                                                busy,
  output logic                                                done,
  input  logic [(feature_n_per_clk+1)*feature_data_width-1:0]   s_axis_data,
  input  logic [(feature_n_per_clk+1)*feature_data_width/8-1:0] s_axis_keep,
  input  logic                                                s_axis_valid,
  output logic                                                s_axis_ready,
  output logic [(feature_n_per_clk+1)*feature_data_width-1:0]   m_axis_data,
  output logic [(feature_n_per_clk+1)*feature_data_width/8-1:0] m_axis_keep,
  output logic                                                m_axis_last,
  output logic                                                m_axis_valid,
  input  logic                                                m_axis_ready,
  input  logic                                                col_valid,
  input  logic                                                col_ready,
  input  logic                                                col_last
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] grp_max_q, grp_max_d;
  logic [15:0] row_max_q, row_max_d;
  logic [15:0] chn_max_q, chn_max_d;
  logic [15:0] grp_cnt_q, grp_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  logic [15:0] chn_cnt_q, chn_cnt_d;
  logic [16:0] out_last_cnt_q, out_last_cnt_d;

  logic st_pass, st_drain;
  logic in_hs, col_hs;
  logic grp_at_max, row_at_max, chn_at_max;

  // The simulation delay has no meaning in the synthesized netlist.
  logic unused_sim_delay;
  assign unused_sim_delay = (simulation_delay > 0.0);

  assign st_pass    = (state_q == ST_PASS);
  assign st_drain   = (state_q == ST_DRAIN);
  assign grp_at_max = (grp_cnt_q == grp_max_q);
  assign row_at_max = (row_cnt_q == row_max_q);
  assign chn_at_max = (chn_cnt_q == chn_max_q);
  assign in_hs      = s_axis_valid & s_axis_ready;
  assign col_hs     = col_valid & col_ready & col_last;

  assign s_axis_ready = st_pass & m_axis_ready;
  assign m_axis_valid = st_pass & s_axis_valid;
  assign m_axis_last  = st_pass & grp_at_max & row_at_max;
  assign m_axis_data  = s_axis_data;
  assign m_axis_keep  = s_axis_keep;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

  always_comb begin
    state_d        = state_q;
    grp_max_d      = grp_max_q;
    row_max_d      = row_max_q;
    chn_max_d      = chn_max_q;
    grp_cnt_d      = grp_cnt_q;
    row_cnt_d      = row_cnt_q;
    chn_cnt_d      = chn_cnt_q;
    out_last_cnt_d = out_last_cnt_q;

    if ((st_pass || st_drain) && col_hs) begin
      out_last_cnt_d = out_last_cnt_q + 17'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          grp_max_d      = cfg_grp_per_row;
          row_max_d      = cfg_row_n;
          chn_max_d      = cfg_chn_n;
          grp_cnt_d      = 16'd0;
          row_cnt_d      = 16'd0;
          chn_cnt_d      = 16'd0;
          out_last_cnt_d = 17'd0;
          state_d        = ST_PASS;
        end
      end
      ST_PASS: begin
        if (in_hs) begin
          // The final group of the final map ends the stream; counters freeze there.
          if (grp_at_max && row_at_max && chn_at_max) begin
            state_d = ST_DRAIN;
          end else if (!grp_at_max) begin
            grp_cnt_d = grp_cnt_q + 16'd1;
          end else begin
            grp_cnt_d = 16'd0;
            if (!row_at_max) begin
              row_cnt_d = row_cnt_q + 16'd1;
            end else begin
              row_cnt_d = 16'd0;
              chn_cnt_d = chn_cnt_q + 16'd1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (out_last_cnt_d == ({1'b0, chn_max_q} + 17'd1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grp_max_q      <= 16'd0;
      row_max_q      <= 16'd0;
      chn_max_q      <= 16'd0;
      grp_cnt_q      <= 16'd0;
      row_cnt_q      <= 16'd0;
      chn_cnt_q      <= 16'd0;
      out_last_cnt_q <= 17'd0;
    end else begin
      state_q        <= state_d;
      grp_max_q      <= grp_max_d;
      row_max_q      <= row_max_d;
      chn_max_q      <= chn_max_d;
      grp_cnt_q      <= grp_cnt_d;
      row_cnt_q      <= row_cnt_d;
      chn_cnt_q      <= chn_cnt_d;
      out_last_cnt_q <= out_last_cnt_d;
    end
  end

endmodule

// File: tb/tb_max_pool_stream_scheduler.sv
// Scoreboard bench for max_pool_stream_scheduler: randomized groups, expected beats queued by the
// driver from a map/row/group index model, popped and compared by an independent output monitor.
module tb_max_pool_stream_scheduler;
  localparam int FN = 4;
  localparam int FW = 8;
  localparam int DW = (FN + 1) * FW;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_grp = 16'd0;
  logic [15:0]   cfg_row = 16'd0;
  logic [15:0]   cfg_chn = 16'd0;
  logic          busy, done;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last, m_valid;
  logic          m_ready = 1'b0;
  logic          col_valid = 1'b0, col_ready = 1'b0, col_last = 1'b0;

  int    nvec = 0;
  int    nerr = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  max_pool_stream_scheduler #(
    .feature_n_per_clk (FN),
    .feature_data_width(FW),
    .simulation_delay  (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_grp_per_row(cfg_grp),
    .cfg_row_n      (cfg_row),
    .cfg_chn_n      (cfg_chn),
    .busy           (busy),
    .done           (done),
    .s_axis_data    (s_data),
    .s_axis_keep    (s_keep),
    .s_axis_valid   (s_valid),
    .s_axis_ready   (s_ready),
    .m_axis_data    (m_data),
    .m_axis_keep    (m_keep),
    .m_axis_last    (m_last),
    .m_axis_valid   (m_valid),
    .m_axis_ready   (m_ready),
    .col_valid      (col_valid),
    .col_ready      (col_ready),
    .col_last       (col_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 64'(m_data), 64'(mon_e.d));
        chk("out_keep", 64'(m_keep), 64'(mon_e.k));
        chk("out_last", 64'(m_last), 64'(mon_e.l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    start   = 1'($urandom_range(0, 1));
    cfg_grp = 16'($urandom);
    cfg_row = 16'($urandom);
    cfg_chn = 16'($urandom);
  endtask

  task automatic begin_run(input int g, input int r, input int c);
    start   = 1'b1;
    cfg_grp = 16'(g);
    cfg_row = 16'(r);
    cfg_chn = 16'(c);
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic run_groups(input int g, input int r, input int c, input int n_send,
                            input bit bp, input bit junk, input bit col_on_final);
    int gn    = g + 1;
    int rn    = r + 1;
    int total = gn * rn * (c + 1);
    for (int k = 0; k < n_send; k++) begin
      beat_t       b;
      logic [63:0] rnd;
      bit          hs;
      int          budget;
      if (bp) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          m_ready = 1'($urandom_range(0, 1));
          if (junk) drive_junk();
          tick();
        end
      end
      rnd = {$urandom, $urandom};
      b.d = rnd[DW-1:0];
      rnd = {32'd0, $urandom};
      b.k = rnd[KW-1:0];
      b.l = ((k % gn) == gn - 1) && (((k / gn) % rn) == rn - 1);
      s_data  = b.d;
      s_keep  = b.k;
      s_valid = 1'b1;
      exp_q.push_back(b);
      if (col_on_final && k == total - 1) begin
        col_valid = 1'b1;
        col_ready = 1'b1;
        col_last  = 1'b1;
      end
      hs     = 1'b0;
      budget = 0;
      while (!hs && budget < 200) begin
        m_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (junk) drive_junk();
        @(negedge clk);
        chk("m_valid_follows", 64'(m_valid), 64'd1);
        chk("s_ready_follows", 64'(s_ready), 64'(m_ready));
        hs = s_ready;
        tick();
        budget++;
      end
      if (!hs) chk("handshake_timeout", 64'd0, 64'd1);
      col_valid = 1'b0;
      col_ready = 1'b0;
      col_last  = 1'b0;
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic check_drain();
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_m_valid", 64'(m_valid), 64'd0);
    chk("drain_s_ready", 64'(s_ready), 64'd0);
    chk("drain_m_last", 64'(m_last), 64'd0);
    chk("drain_done", 64'(done), 64'd0);
    s_valid = 1'b0;
  endtask

  task automatic col_pulse();
    col_valid = 1'b1;
    col_ready = 1'b1;
    col_last  = 1'b1;
    tick();
    col_valid = 1'b0;
    col_ready = 1'b0;
    col_last  = 1'b0;
  endtask

  task automatic finish_check();
    col_pulse();
    chk("done_next_cycle", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_low_after_done", 64'(busy), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      tick();
      t++;
    end
    chk("done_seen", 64'(done), 64'd1);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_low_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b1;
    m_ready = 1'b1;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_m_valid_after_rst", 64'(m_valid), 64'd0);

    // 3 groups x 2 rows x 1 map
    begin_run(2, 1, 0);
    run_groups(2, 1, 0, 6, 1'b0, 1'b0, 1'b0);
    check_drain();
    finish_check();
    repeat (2) tick();

    // 4 single-group maps, all collector lasts arriving during DRAIN
    begin_run(0, 0, 3);
    run_groups(0, 0, 3, 4, 1'b0, 1'b0, 1'b0);
    check_drain();
    repeat (3) begin
      col_pulse();
      tick();
      chk("no_done_early", 64'(done), 64'd0);
      chk("busy_waiting", 64'(busy), 64'd1);
    end
    finish_check();
    repeat (2) tick();

    // 4 maps, three lasts during PASS and the fourth with the final input handshake
    begin_run(0, 0, 3);
    repeat (3) col_pulse();
    run_groups(0, 0, 3, 4, 1'b0, 1'b0, 1'b1);
    chk("coincident_busy", 64'(busy), 64'd1);
    wait_done(4);
    repeat (2) tick();

    // Backpressure with junk start/cfg during the whole run
    begin_run(3, 2, 1);
    run_groups(3, 2, 1, 24, 1'b1, 1'b1, 1'b0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check_drain();
    repeat (3) begin
      drive_junk();
      tick();
      chk("junk_drain_busy", 64'(busy), 64'd1);
    end
    start = 1'b0;
    col_pulse();
    chk("one_of_two_no_done", 64'(done), 64'd0);
    tick();
    finish_check();
    repeat (2) tick();

    // Reset after 5 of 12 groups
    begin_run(3, 2, 0);
    run_groups(3, 2, 0, 5, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_m_last", 64'(m_last), 64'd0);
    exp_q.delete();
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_done", 64'(done), 64'd0);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // Minimum run
    begin_run(0, 0, 0);
    run_groups(0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    check_drain();
    finish_check();
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/max_pool_stream_scheduler.md
# max_pool_stream_scheduler

Sequencer in front of the max-pool packet collector. It gates the pooling-core output stream per run, counts output groups, rows and channels from a configuration latched at start, and attaches `last` to the final group of every output feature map (channel). It then monitors the collector's output stream and reports completion once every map's final packet has left the collector.

## Interface
Parameters:
- `feature_n_per_clk`, 4, output features per clk of the collector. Input group width is `feature_n_per_clk+1` items.
- `feature_data_width`, 8, feature width in bits. Divisible by 8 and >0.
- `simulation_delay`, 1, real, register update delay for simulation.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run start pulse. Honoured only in IDLE.
- `cfg_grp_per_row`  in  16  groups per output row minus 1.
- `cfg_row_n`  in  16  output rows per map minus 1.
- `cfg_chn_n`  in  16  channels (maps) minus 1.
- `busy`  out  1  run in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `s_axis_data`  in  (feature_n_per_clk+1)*feature_data_width  pooling-core group data.
- `s_axis_keep`  in  (feature_n_per_clk+1)*feature_data_width/8  byte enables.
- `s_axis_valid`  in  1  input valid.
- `s_axis_ready`  out  1  input ready.
- `m_axis_data`, `m_axis_keep`  out  same widths as the `s_axis_*` equivalents  to collector.
- `m_axis_last`  out  1  last group of current map.
- `m_axis_valid`  out  1  output valid.
- `m_axis_ready`  in  1  collector ready.
- `col_valid`, `col_ready`, `col_last`  in  1 each  snoop of collector output handshake.

## Operation
- States: IDLE, PASS, DRAIN, DONE.
- IDLE, `start`=1:
  - Latch the three cfg fields into shadow registers.
  - Clear `grp_cnt`, `row_cnt`, `chn_cnt` and `out_last_cnt`.
  - Go to PASS.
- PASS is a combinational pass-through:
  - `m_axis_valid = s_axis_valid`, `s_axis_ready = m_axis_ready`.
  - Data and keep are passed unmodified.
  - In other states, `m_axis_valid` = 0 and `s_axis_ready` = 0.
- `m_axis_last` = (`grp_cnt`==grp_max) & (`row_cnt`==row_max). It is valid only in PASS and forced to 0 elsewhere.
- On an input handshake (`s_axis_valid & s_axis_ready`):
  - `grp_cnt` increments. At grp_max it wraps to 0 and `row_cnt` increments.
  - At row_max `row_cnt` wraps and `chn_cnt` increments.
  - The handshake where all three counters are at their max moves PASS→DRAIN. Counters are not advanced on that handshake.
- `out_last_cnt` (17 bits) increments on every `col_valid & col_ready & col_last` in PASS or DRAIN. This includes a beat in the same cycle as the final input handshake.
- DRAIN→DONE when `out_last_cnt` (including the current-cycle increment) equals `cfg_chn_n`+1.
- DONE lasts exactly 1 cycle, then → IDLE. `done` = (state==DONE).
- `start` outside IDLE is ignored. Cfg inputs are don't-care outside the IDLE start cycle.
- Collector last beats seen in IDLE or DONE are ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `m_axis_valid`=0, `s_axis_ready`=0, `m_axis_last`=0. State = IDLE, all counters 0.
- Data path latency is 0 cycles (combinational). The block adds no buffering and never drops or duplicates a beat.
- Start → first acceptable input: the cycle after `start`.
- Final collector last handshake in cycle N → `done`=1 in cycle N+1 → `busy`=0 in cycle N+2.
- A new `start` is accepted from cycle N+2.
- Minimum run with all cfg=0: one input group, `m_axis_last`=1 on it.
- Reset asserted mid-run: immediately IDLE, all outputs to reset values. A partial map is abandoned and no `done` is issued.
- AXIS rule: `m_axis_valid` follows `s_axis_valid` without waiting for `m_axis_ready`. Backpressure stalls all counters.

## Test plan
- cfg grp=2, row=1, chn=0; 6 groups, ready always 1 → `m_axis_last` only on group 6. DRAIN after group 6. Drive one col last → `done` pulse 1 cycle later, `busy` low the cycle after that.
- cfg grp=0, row=0, chn=3; 4 groups → last on every group. `done` only after the 4th col last. Also drive col last in the same cycle as the final input handshake → counted, `done` still on the correct cycle.
- Random `m_axis_ready` backpressure with grp=3, row=2, chn=1 → 24 groups passed with data and keep bit-exact, last on groups 12 and 24, no loss.
- `start` pulsed during PASS and during DRAIN → ignored; cfg changes mid-run have no effect on last positions.
- `rst_n` low after 5 of 12 groups → outputs to reset values at once, no `done`. A new run with grp=0, row=0, chn=0 then completes normally.
